// File: rtl/processing_element_controller_pkg.sv
// Shared MMIO widths and controller state encoding for the processing-element host sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package processing_element_controller_pkg;

    localparam int TIA_MMIO_INDEX_WIDTH = 8;
    localparam int TIA_MMIO_DATA_WIDTH  = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_WRITE,
        ST_RUN,
        ST_READ,
        ST_RESULT,
        ST_DONE,
        ST_ERROR
    } processing_element_controller_state_t;

endpackage

// File: rtl/processing_element_controller_mmio_host_port.sv
// Single outstanding MMIO transaction engine (write or read) over a req/ack host interface.
// Latency: req rises the cycle after a start pulse; the done pulse coincides with the ack cycle.
// Backpressure: req, index and data hold until ack; an ack while req is low is ignored.
module mmio_host_port
    import processing_element_controller_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            write_start,
    input  logic                            read_start,
    input  logic [TIA_MMIO_INDEX_WIDTH-1:0] start_index,
    input  logic [TIA_MMIO_DATA_WIDTH-1:0]  start_data,
    input  logic                            write_ack,
    input  logic                            read_ack,
    input  logic [TIA_MMIO_DATA_WIDTH-1:0]  read_data,
    output logic                            write_req,
    output logic                            read_req,
    output logic [TIA_MMIO_INDEX_WIDTH-1:0] index,
    output logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data,
    output logic [TIA_MMIO_DATA_WIDTH-1:0]  read_result,
    output logic                            write_done,
    output logic                            read_done
);

    assign write_done = write_req & write_ack;
    assign read_done  = read_req & read_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            write_req   <= 1'b0;
            read_req    <= 1'b0;
            index       <= '0;
            write_data  <= '0;
            read_result <= '0;
        end else begin
            if (write_start) begin
                write_req  <= 1'b1;
                index      <= start_index;
                write_data <= start_data;
            end else if (write_done) begin
                write_req <= 1'b0;
            end

            if (read_start) begin
                read_req <= 1'b1;
                index    <= start_index;
            end else if (read_done) begin
                read_req    <= 1'b0;
                read_result <= read_data;
            end
        end
    end

endmodule

// File: rtl/processing_element_controller.sv
// Host-side PE sequencer: config load over MMIO, run to quiescence or timeout, MMIO readback stream.
// Latency: 3+ cycles per config word, 1 cycle start-to-RUN when empty, 2+ cycles per readback word.
// Backpressure: MMIO stalls on write/read ack; the result stream holds valid/index/data until ready.
module processing_element_controller
    import processing_element_controller_pkg::*;
#(
    parameter int CONFIG_ADDR_WIDTH = 8,
    parameter int TIMEOUT_WIDTH     = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CONFIG_ADDR_WIDTH:0]      config_length,
    input  logic [TIA_MMIO_INDEX_WIDTH-1:0] result_base_index,
    input  logic [TIA_MMIO_INDEX_WIDTH-1:0] result_count,
    input  logic [TIMEOUT_WIDTH-1:0]        timeout_limit,
    output logic                            config_read_en,
    output logic [CONFIG_ADDR_WIDTH-1:0]    config_read_addr,
    input  logic [TIA_MMIO_INDEX_WIDTH-1:0] config_read_index,
    input  logic [TIA_MMIO_DATA_WIDTH-1:0]  config_read_data,
    output logic                            pe_enable,
    output logic                            pe_execute,
    input  logic                            pe_halted,
    input  logic                            pe_channels_quiescent,
    input  logic                            pe_router_quiescent,
    output logic                            host_interface_write_req,
    input  logic                            host_interface_write_ack,
    output logic [TIA_MMIO_INDEX_WIDTH-1:0] host_interface_write_index,
    output logic [TIA_MMIO_DATA_WIDTH-1:0]  host_interface_write_data,
    output logic                            host_interface_read_req,
    input  logic                            host_interface_read_ack,
    output logic [TIA_MMIO_INDEX_WIDTH-1:0] host_interface_read_index,
    input  logic [TIA_MMIO_DATA_WIDTH-1:0]  host_interface_read_data,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [TIA_MMIO_INDEX_WIDTH-1:0] result_index,
    output logic [TIA_MMIO_DATA_WIDTH-1:0]  result_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int CW = CONFIG_ADDR_WIDTH + 1;
    localparam int IW = TIA_MMIO_INDEX_WIDTH;

    processing_element_controller_state_t state, state_nxt;

    logic [CW-1:0]            cfg_len_q;
    logic [CW-1:0]            word_cnt;
    logic [IW-1:0]            base_q;
    logic [IW-1:0]            res_cnt_q;
    logic [IW-1:0]            res_k;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic [TIMEOUT_WIDTH-1:0] run_cnt;

    logic          accept;
    logic          wr_issue;
    logic          rd_issue;
    logic          wr_done;
    logic          rd_done;
    logic [IW-1:0] port_index;
    logic [IW-1:0] rd_issue_index;
    logic [IW-1:0] issue_index;
    logic [TIA_MMIO_DATA_WIDTH-1:0] port_rdata;

    logic last_word;
    logic last_result;
    logic run_complete;
    logic run_timeout;

    assign last_word    = (word_cnt + CW'(1)) == cfg_len_q;
    assign last_result  = (res_k + IW'(1)) == res_cnt_q;
    assign run_complete = pe_halted & pe_channels_quiescent & pe_router_quiescent;
    // run_cnt counts RUN cycles already completed, so +1 includes the current one.
    assign run_timeout  = (timeout_q != '0) && ((run_cnt + TIMEOUT_WIDTH'(1)) == timeout_q);

    // In RUN res_k is still 0; in RESULT the next read follows the word being handed off.
    assign rd_issue_index = base_q + ((state == ST_RESULT) ? (res_k + IW'(1)) : res_k);
    assign issue_index    = wr_issue ? config_read_index : rd_issue_index;

    mmio_host_port u_port (
        .clock       (clock),
        .reset       (reset),
        .write_start (wr_issue),
        .read_start  (rd_issue),
        .start_index (issue_index),
        .start_data  (config_read_data),
        .write_ack   (host_interface_write_ack),
        .read_ack    (host_interface_read_ack),
        .read_data   (host_interface_read_data),
        .write_req   (host_interface_write_req),
        .read_req    (host_interface_read_req),
        .index       (port_index),
        .write_data  (host_interface_write_data),
        .read_result (port_rdata),
        .write_done  (wr_done),
        .read_done   (rd_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wr_issue  = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (config_length != '0) ? ST_FETCH : ST_RUN;
                end
            end
            ST_FETCH:   state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                wr_issue  = 1'b1;
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_done) begin
                    state_nxt = last_word ? ST_RUN : ST_FETCH;
                end
            end
            ST_RUN: begin
                if (run_complete) begin
                    if (res_cnt_q == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        rd_issue  = 1'b1;
                        state_nxt = ST_READ;
                    end
                end else if (run_timeout) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_READ: begin
                if (rd_done) begin
                    state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (result_ready) begin
                    if (last_result) begin
                        state_nxt = ST_DONE;
                    end else begin
                        rd_issue  = 1'b1;
                        state_nxt = ST_READ;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_len_q <= '0;
            word_cnt  <= '0;
            base_q    <= '0;
            res_cnt_q <= '0;
            res_k     <= '0;
            timeout_q <= '0;
            run_cnt   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (accept) begin
                cfg_len_q <= config_length;
                base_q    <= result_base_index;
                res_cnt_q <= result_count;
                timeout_q <= timeout_limit;
                word_cnt  <= '0;
                res_k     <= '0;
            end else begin
                if (state == ST_WRITE && wr_done) begin
                    word_cnt <= word_cnt + CW'(1);
                end
                if (state == ST_RESULT && result_ready) begin
                    res_k <= res_k + IW'(1);
                end
            end
            run_cnt <= (state == ST_RUN) ? (run_cnt + TIMEOUT_WIDTH'(1)) : '0;
            done    <= accept ? 1'b0 : (done | (state_nxt == ST_DONE));
            error   <= accept ? 1'b0 : (error | (state_nxt == ST_ERROR));
        end
    end

    assign config_read_en             = (state == ST_FETCH);
    assign config_read_addr           = config_read_en ? word_cnt[CONFIG_ADDR_WIDTH-1:0] : '0;
    assign pe_enable                  = (state != ST_IDLE);
    assign pe_execute                 = (state == ST_RUN);
    assign host_interface_write_index = port_index;
    assign host_interface_read_index  = port_index;
    assign result_valid               = (state == ST_RESULT);
    assign result_index               = port_index;
    assign result_data                = port_rdata;
    assign busy = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

endmodule

// File: tb/tb_processing_element_controller.sv
// Scoreboard bench: stimulus pushes expected MMIO writes, reads, results and run outcomes;
// independent monitors/responders pop and compare as the DUT produces them.
module tb_processing_element_controller;
    import processing_element_controller_pkg::*;

    localparam int IW = TIA_MMIO_INDEX_WIDTH;
    localparam int DW = TIA_MMIO_DATA_WIDTH;
    localparam int AW = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset, start;
    logic [AW:0]    config_length;
    logic [IW-1:0]  result_base_index, result_count;
    logic [31:0]    timeout_limit;
    logic           config_read_en;
    logic [AW-1:0]  config_read_addr;
    logic [IW-1:0]  config_read_index = '0;
    logic [DW-1:0]  config_read_data = '0;
    logic           pe_enable, pe_execute;
    logic           pe_halted, pe_channels_quiescent, pe_router_quiescent;
    logic           host_interface_write_req, host_interface_write_ack;
    logic [IW-1:0]  host_interface_write_index;
    logic [DW-1:0]  host_interface_write_data;
    logic           host_interface_read_req, host_interface_read_ack;
    logic [IW-1:0]  host_interface_read_index;
    logic [DW-1:0]  host_interface_read_data;
    logic           result_valid, result_ready;
    logic [IW-1:0]  result_index;
    logic [DW-1:0]  result_data;
    logic           busy, done, error;

    processing_element_controller #(.CONFIG_ADDR_WIDTH(AW), .TIMEOUT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start),
        .config_length(config_length), .result_base_index(result_base_index),
        .result_count(result_count), .timeout_limit(timeout_limit),
        .config_read_en(config_read_en), .config_read_addr(config_read_addr),
        .config_read_index(config_read_index), .config_read_data(config_read_data),
        .pe_enable(pe_enable), .pe_execute(pe_execute), .pe_halted(pe_halted),
        .pe_channels_quiescent(pe_channels_quiescent), .pe_router_quiescent(pe_router_quiescent),
        .host_interface_write_req(host_interface_write_req),
        .host_interface_write_ack(host_interface_write_ack),
        .host_interface_write_index(host_interface_write_index),
        .host_interface_write_data(host_interface_write_data),
        .host_interface_read_req(host_interface_read_req),
        .host_interface_read_ack(host_interface_read_ack),
        .host_interface_read_index(host_interface_read_index),
        .host_interface_read_data(host_interface_read_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_index(result_index), .result_data(result_data),
        .busy(busy), .done(done), .error(error)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int wr_ack_cyc = 0;
    bit resp_en = 1'b1;
    logic spurious_ack = 1'b0;
    int ready_mode = 0;
    int halt_at = 1, chan_at = 1, rtr_at = 1;

    logic [DW-1:0] pe_regs [256];
    logic [IW-1:0] cfg_idx [256];
    logic [DW-1:0] cfg_dat [256];

    logic [IW+DW-1:0] exp_wr_q [$];
    logic [IW+DW-1:0] exp_res_q [$];
    logic [IW-1:0]    exp_rd_q [$];
    int               exp_run_q [$];
    logic [1:0]       exp_exit_q [$];
    int               wr_delay_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous config memory: word appears one cycle after the strobe.
    always @(posedge clock) begin
        if (config_read_en) begin
            config_read_index <= cfg_idx[config_read_addr];
            config_read_data  <= cfg_dat[config_read_addr];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({config_read_en, config_read_addr, pe_enable, pe_execute,
                     host_interface_write_req, host_interface_write_index, host_interface_write_data,
                     host_interface_read_req, host_interface_read_index,
                     result_valid, result_index, result_data, busy, done, error});
    endfunction

    // PE status model: each flag rises at its configured RUN cycle number.
    initial begin : pe_model
        int n;
        n = 0;
        pe_halted = 1'b0; pe_channels_quiescent = 1'b0; pe_router_quiescent = 1'b0;
        forever begin
            @(negedge clock);
            if (pe_execute) n++; else n = 0;
            pe_halted             = (n != 0) && (n >= halt_at);
            pe_channels_quiescent = (n != 0) && (n >= chan_at);
            pe_router_quiescent   = (n != 0) && (n >= rtr_at);
        end
    end

    initial begin : wr_resp
        int left; bit pend; bit acked; logic [IW+DW-1:0] first, cur;
        left = 0; pend = 0; acked = 0; first = '0;
        host_interface_write_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (!resp_en) begin
                host_interface_write_ack = spurious_ack;
                pend = 0; acked = 0;
            end else begin
                host_interface_write_ack = 1'b0;
                cur = {host_interface_write_index, host_interface_write_data};
                if (acked) chk("wr_gap_req_low", 128'(host_interface_write_req), 128'(0));
                acked = 0;
                if (host_interface_write_req) begin
                    if (!pend) begin
                        pend = 1; first = cur;
                        left = (wr_delay_q.size() > 0) ? wr_delay_q.pop_front() : int'($urandom_range(0, 3));
                    end else begin
                        chk("wr_stable", 128'(cur), 128'(first));
                    end
                    if (left == 0) begin
                        host_interface_write_ack = 1'b1;
                        pend = 0; acked = 1;
                        pe_regs[host_interface_write_index] = host_interface_write_data;
                        wr_ack_cyc = cyc;
                        chk("wr_expected_pending", 128'(exp_wr_q.size() > 0), 128'(1));
                        if (exp_wr_q.size() > 0) chk("wr_word", 128'(cur), 128'(exp_wr_q.pop_front()));
                    end else begin
                        left--;
                    end
                end else begin
                    pend = 0;
                end
            end
        end
    end

    initial begin : rd_resp
        int left; bit pend; bit acked; logic [IW-1:0] first;
        left = 0; pend = 0; acked = 0; first = '0;
        host_interface_read_ack = 1'b0;
        host_interface_read_data = '0;
        forever begin
            @(negedge clock);
            host_interface_read_ack = 1'b0;
            host_interface_read_data = $urandom;
            if (acked) chk("rd_gap_req_low", 128'(host_interface_read_req), 128'(0));
            acked = 0;
            if (resp_en && host_interface_read_req) begin
                if (!pend) begin
                    pend = 1; first = host_interface_read_index; left = $urandom_range(0, 3);
                end else begin
                    chk("rd_stable", 128'(host_interface_read_index), 128'(first));
                end
                if (left == 0) begin
                    host_interface_read_ack = 1'b1;
                    host_interface_read_data = pe_regs[host_interface_read_index];
                    pend = 0; acked = 1;
                    chk("rd_expected_pending", 128'(exp_rd_q.size() > 0), 128'(1));
                    if (exp_rd_q.size() > 0) chk("rd_index", 128'(host_interface_read_index), 128'(exp_rd_q.pop_front()));
                end else begin
                    left--;
                end
            end else begin
                pend = 0;
            end
        end
    end

    initial begin : res_mon
        int thr;
        thr = 0;
        result_ready = 1'b0;
        forever begin
            @(negedge clock);
            case (ready_mode)
                1:       result_ready = (thr % 3 == 2);
                2:       result_ready = 1'($urandom_range(0, 1));
                default: result_ready = 1'b1;
            endcase
            thr++;
            if (result_valid && result_ready) begin
                chk("res_expected_pending", 128'(exp_res_q.size() > 0), 128'(1));
                if (exp_res_q.size() > 0) chk("result_word", 128'({result_index, result_data}), 128'(exp_res_q.pop_front()));
            end
        end
    end

    initial begin : exec_mon
        int len; bit prev; logic [1:0] ex; int last;
        len = 0; prev = 0;
        forever begin
            @(negedge clock);
            if (pe_execute) begin
                if (!prev) begin
                    last = (wr_ack_cyc > start_cyc) ? wr_ack_cyc : start_cyc;
                    chk("exec_rise_delay", 128'(cyc - last), 128'(1));
                end
                len++;
            end else if (prev) begin
                chk("run_expected_pending", 128'(exp_run_q.size() > 0), 128'(1));
                if (exp_run_q.size() > 0) begin
                    chk("run_cycles", 128'(len), 128'(exp_run_q.pop_front()));
                    ex = exp_exit_q.pop_front();
                    chk("exit_done_error", 128'({done, error}), 128'(ex));
                end
                len = 0;
            end
            prev = pe_execute;
        end
    end

    // Reference: PE registers after the config words, run length from the flag/timeout rules.
    task automatic run_job(input int len, input logic [IW-1:0] base, input logic [IW-1:0] cnt,
                           input logic [31:0] tmo, input int h, input int ch, input int rt, input int rmode);
        logic [DW-1:0] model [256];
        logic [IW-1:0] ri;
        int comp, runlen, n;
        bit to;
        model = pe_regs;
        for (int i = 0; i < len; i++) begin
            exp_wr_q.push_back({cfg_idx[i], cfg_dat[i]});
            model[cfg_idx[i]] = cfg_dat[i];
        end
        comp = h;
        if (ch > comp) comp = ch;
        if (rt > comp) comp = rt;
        to = (tmo != 0) && (int'(tmo) < comp);
        runlen = to ? int'(tmo) : comp;
        exp_run_q.push_back(runlen);
        exp_exit_q.push_back({!to && cnt == 0, to});
        if (!to) begin
            for (int k = 0; k < int'(cnt); k++) begin
                ri = base + IW'(k);
                exp_rd_q.push_back(ri);
                exp_res_q.push_back({ri, model[ri]});
            end
        end
        config_length = (AW+1)'(len);
        result_base_index = base;
        result_count = cnt;
        timeout_limit = tmo;
        halt_at = h; chan_at = ch; rtr_at = rt;
        ready_mode = rmode;
        @(negedge clock);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
        chk("after_start_busy_done_error", 128'({busy, done, error}), 128'(3'b100));
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("job_finished", 128'(busy), 128'(0));
        @(negedge clock);
        chk("final_done_error", 128'({done, error}), 128'({!to, to}));
        chk("enable_held", 128'(pe_enable), 128'(1));
        chk("scoreboard_drained", 128'(exp_wr_q.size() + exp_rd_q.size() + exp_res_q.size() + exp_run_q.size()), 128'(0));
    endtask

    task automatic reset_mid_write();
        int n;
        resp_en = 1'b0;
        spurious_ack = 1'b0;
        cfg_idx[0] = 8'h33; cfg_dat[0] = 32'h1234_5678;
        config_length = 1; result_count = 0; timeout_limit = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!host_interface_write_req && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("rst_write_req_seen", 128'(host_interface_write_req), 128'(1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_outputs_zero", all_outputs(), 128'(0));
        spurious_ack = 1'b1;
        repeat (2) @(negedge clock);
        chk("spurious_ack_ignored", all_outputs(), 128'(0));
        spurious_ack = 1'b0;
        @(negedge clock);
        resp_en = 1'b1;
    endtask

    initial begin : main
        logic [31:0] tmo;
        int len;
        for (int i = 0; i < 256; i++) begin
            pe_regs[i] = $urandom;
            cfg_idx[i] = '0;
            cfg_dat[i] = '0;
        end
        reset = 1'b1; start = 1'b0;
        config_length = '0; result_base_index = '0; result_count = '0; timeout_limit = '0;
        repeat (3) @(negedge clock);
        chk("reset_outputs_zero", all_outputs(), 128'(0));
        reset = 1'b0;
        @(negedge clock);
        chk("idle_outputs_zero", all_outputs(), 128'(0));

        cfg_idx[0] = 8'h04; cfg_dat[0] = 32'hA;
        cfg_idx[1] = 8'h05; cfg_dat[1] = 32'hB;
        cfg_idx[2] = 8'h10; cfg_dat[2] = 32'hC;
        wr_delay_q.push_back(0); wr_delay_q.push_back(2); wr_delay_q.push_back(5);
        run_job(3, 8'h20, 8'd2, 32'd0, 20, 1, 25, 1);

        run_job(0, 8'h00, 8'd1, 32'd10, 1000, 1, 1, 0);
        run_job(0, 8'h00, 8'd0, 32'd0, 3, 3, 3, 0);

        cfg_idx[0] = 8'h07; cfg_dat[0] = 32'hDEAD_BEEF;
        run_job(1, 8'hFF, 8'd2, 32'd0, 5, 2, 4, 2);

        run_job(0, 8'h40, 8'd1, 32'd6, 6, 6, 6, 0);

        reset_mid_write();

        for (int j = 0; j < 10; j++) begin
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) begin
                cfg_idx[i] = IW'($urandom);
                cfg_dat[i] = $urandom;
            end
            tmo = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(5, 40)) : 32'd0;
            run_job(len, IW'($urandom), IW'($urandom_range(0, 5)), tmo,
                    $urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 30),
                    $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
